mem_bist_ctrl: RTL and testbench

//  Synthesizable memory self-test engine, parametrised in address/data width and test mode.

---
 rtl/mem_bist_pkg.sv | 23 ++
 rtl/mem_bist_patgen.sv | 26 ++
 rtl/mem_bist_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_bist_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared types and pattern constants for the memory self-test engine
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    DONE
  } bist_state_t;

  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,
    MODE_ADDR    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_ALL     = 2'd3
  } bist_mode_t;

  // Replicated DATA_W/2 times to form the even/odd checkerboard words.
  localparam logic [1:0] CHECKER_EVEN = 2'b10;
  localparam logic [1:0] CHECKER_ODD  = 2'b01;

endpackage

// File: rtl/mem_bist_patgen.sv
// rtl/mem_bist_patgen.sv - expected data for a given address and pattern index
module mem_bist_patgen
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        pattern,
  output logic [DATA_W-1:0] exp_data
);

  // Widened copy so the address can be zero-extended or truncated with one slice.
  logic [ADDR_W+DATA_W-1:0] addr_ext;
  assign addr_ext = {{DATA_W{1'b0}}, addr};

  always_comb begin
    exp_data = '0;
    case (pattern)
      2'd1:    exp_data = addr_ext[DATA_W-1:0];
      2'd2:    exp_data = addr[0] ? {(DATA_W/2){CHECKER_ODD}} : {(DATA_W/2){CHECKER_EVEN}};
      default: exp_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - write-all / read-compare memory self-test engine
// Optional first-miscompare logging: MEM_BIST_ERR_LOG_EN.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  bist_state_t       state, state_d;
  bist_mode_t        run_mode;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        pattern;
  logic [DATA_W-1:0] exp_data;
  logic [ERR_W-1:0]  err_d;
  logic              last_addr, more_patterns, miscompare, launch, aborting;

  mem_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_patgen (
    .addr     (addr),
    .pattern  (pattern),
    .exp_data (exp_data)
  );

  assign last_addr     = (addr == LAST_ADDR);
  assign more_patterns = (run_mode == MODE_ALL) && (pattern != 2'd2);
  assign launch        = (state == IDLE) && start && !abort;
  assign aborting      = (state != IDLE) && abort;
  // Case inequality so X/Z read data counts as a miscompare in simulation.
  assign miscompare    = (state == CHECK) && (mem_rdata !== exp_data);

  always_comb begin
    err_d = err_count;
    if (miscompare && (err_count != '1)) err_d = err_count + ERR_W'(1);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (launch) state_d = WRITE;
      WRITE:   if (last_addr) state_d = READ;
      READ:    state_d = CHECK;
      CHECK:   if (last_addr) state_d = more_patterns ? WRITE : DONE;
               else state_d = READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (aborting) state_d = IDLE;
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_write = (state == WRITE);
  assign mem_read  = (state == READ);
  assign mem_addr  = addr;
  assign mem_wdata = mem_write ? exp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_mode  <= MODE_CLEAR;
      addr      <= '0;
      pattern   <= 2'd0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (launch) begin
          err_count <= '0;
          pass      <= 1'b0;
          run_mode  <= bist_mode_t'(mode);
          pattern   <= (mode == 2'd3) ? 2'd0 : mode;
          addr      <= '0;
        end
        WRITE: addr <= addr + ADDR_W'(1);
        CHECK: begin
          err_count <= err_d;
          addr      <= addr + ADDR_W'(1);
          if (last_addr && more_patterns) pattern <= pattern + 2'd1;
        end
        default: ;
      endcase
      // pass is settled on entry to DONE so it is already valid while done is high.
      if (state_d == DONE) pass <= (err_d == '0);
      if (aborting) begin
        pass <= 1'b0;
        addr <= '0;
      end
    end
  end

`ifdef MEM_BIST_ERR_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (launch) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (miscompare && (err_count == '0)) begin
      first_err_addr <= addr;
      first_err_data <= mem_rdata;
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - directed self-checking bench for mem_bist_ctrl with a fault-injecting memory model
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [4:0] first_err_addr;
  logic [7:0] first_err_data;
  logic       mem_write, mem_read;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [32];
  int         fault = 0;
  int         wr_idx = 0, wr_bad = 0, both_hi = 0;
  logic [1:0] mon_mode = 2'd0;
  logic       pass_at_done;

  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .ERR_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with injectable faults: 1 = bit 3 of addr 5 stuck at 1, 2 = reads all ones.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) begin
      case (fault)
        1:       mem_rdata <= (mem_addr == 5'd5) ? (mem[mem_addr] | 8'h08) : mem[mem_addr];
        2:       mem_rdata <= 8'hFF;
        default: mem_rdata <= mem[mem_addr];
      endcase
    end
  end

  // Write-stream monitor: checks order and data of every write against the pattern sequence.
  always @(negedge clk) begin
    int         pat;
    logic [7:0] exp_w;
    if (mem_write && mem_read) both_hi++;
    if (start && !busy && !abort && rst_n) begin
      wr_idx   = 0;
      wr_bad   = 0;
      mon_mode = mode;
    end else if (mem_write) begin
      pat = (mon_mode == 2'd3) ? (wr_idx / 32) : int'(mon_mode);
      case (pat)
        0:       exp_w = 8'h00;
        1:       exp_w = 8'(wr_idx % 32);
        default: exp_w = ((wr_idx % 32) % 2 == 1) ? 8'h55 : 8'hAA;
      endcase
      if (mem_addr !== 5'(wr_idx % 32) || mem_wdata !== exp_w) wr_bad++;
      wr_idx++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_pulse(input logic [1:0] m);
    @(posedge clk); #1;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycle 0 is the edge that samples start; returns the cycle in which done is seen (0 on timeout).
  task automatic run_test(input logic [1:0] m, input int extra_start,
                          output int done_cyc, output int busy_n);
    done_cyc = 0;
    busy_n   = 0;
    start_pulse(m);
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start = (c == extra_start);
      if (busy) busy_n++;
      if (done) begin
        done_cyc     = c;
        pass_at_done = pass;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, bn;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_outs", {done, pass, mem_write, mem_read, err_count, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode 0 clean, with a start pulse mid-test that must be ignored.
    fault = 0;
    run_test(2'd0, 50, dc, bn);
    check_eq("m0_done_cycle", dc, 97);
    check_eq("m0_busy_cycles", bn, 97);
    check_eq("m0_pass", pass_at_done, 1);
    check_eq("m0_err", err_count, 0);
    check_eq("m0_writes", wr_idx, 32);
    check_eq("m0_wdata_bad", wr_bad, 0);
    @(negedge clk);
    check_eq("m0_done_pulse", {done, busy}, 0);

    // Mode 1 with stuck bit at address 5.
    fault = 1;
    run_test(2'd1, 0, dc, bn);
    check_eq("m1_done_cycle", dc, 97);
    check_eq("m1_err", err_count, 1);
    check_eq("m1_pass", pass_at_done, 0);
    check_eq("m1_wdata_bad", wr_bad, 0);
`ifdef MEM_BIST_ERR_LOG_EN
    check_eq("m1_log_addr", first_err_addr, 5'h05);
    check_eq("m1_log_data", first_err_data, 8'h0D);
`else
    check_eq("m1_log_addr", first_err_addr, 0);
    check_eq("m1_log_data", first_err_data, 0);
`endif

    // Mode 2 clean.
    fault = 0;
    run_test(2'd2, 0, dc, bn);
    check_eq("m2_done_cycle", dc, 97);
    check_eq("m2_pass", pass_at_done, 1);
    check_eq("m2_wdata_bad", wr_bad, 0);

    // Mode 3 clean: three patterns back to back.
    run_test(2'd3, 0, dc, bn);
    check_eq("m3_done_cycle", dc, 289);
    check_eq("m3_busy_cycles", bn, 289);
    check_eq("m3_writes", wr_idx, 96);
    check_eq("m3_wdata_bad", wr_bad, 0);
    check_eq("m3_pass", pass_at_done, 1);
    check_eq("m3_err", err_count, 0);

    // All-ones reads saturate the 4-bit error counter.
    fault = 2;
    run_test(2'd0, 0, dc, bn);
    check_eq("sat_done_cycle", dc, 97);
    check_eq("sat_err", err_count, 15);
    check_eq("sat_pass", pass_at_done, 0);

    // Abort in the 10th write cycle, then a clean rerun.
    fault = 0;
    start_pulse(2'd0);
    repeat (10) @(negedge clk);
    check_eq("abort_pre_write", {mem_write, mem_addr}, {1'b1, 5'd9});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_idle", {busy, done, pass, mem_write, mem_read}, 0);
    run_test(2'd0, 0, dc, bn);
    check_eq("rerun_done_cycle", dc, 97);
    check_eq("rerun_pass", pass_at_done, 1);

    // Abort and start together in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_start_idle", busy, 0);

    // Asynchronous reset during the READ of address 7.
    start_pulse(2'd0);
    repeat (47) @(negedge clk);
    check_eq("rst_pre_read", {mem_read, mem_addr}, {1'b1, 5'd7});
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_strobes", {mem_read, mem_write, busy}, 0);
    check_eq("rst_async_err", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    check_eq("strobes_exclusive", both_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
